puzzle_feeder: RTL and testbench
================================

# puzzle_feeder

Producer side of the per-day character interface: buffers puzzle-input bytes loaded through a valid/ready write port, then streams them one per clock on `char_out` to a day solver. It sits between the testbench/host loader and the day module. It marks end-of-input so the solver's accumulated result can be sampled at a defined cycle.

## Interface
- `DEPTH`, 64: FIFO depth in bytes; must be a power of 2, at least 2.
- `IDLE_CHAR`, 8'h00: value driven on `char_out` when no character is valid. It must be a byte that day solvers ignore.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `wr_valid` in 1: loader byte valid.
- `wr_data` in 8: loader byte.
- `wr_last` in 1: qualifies `wr_data` as the final byte of the input.
- `wr_ready` out 1: FIFO can accept a byte this cycle.
- `start` in 1: single-cycle pulse; begins streaming.
- `clear` in 1: single-cycle pulse; returns from DONE to LOAD.
- `char_out` out 8: character presented to the solver, registered.
- `char_valid` out 1: `char_out` holds a real input byte this cycle.
- `char_index` out 32: 1-based position of the byte on `char_out`; holds its last value while stalled.
- `busy` out 1: state is STREAM.
- `done` out 1: state is DONE; the last byte was presented on the previous cycle or earlier.

## Operation
- FIFO entry is 9 bits: {last, data}. A push occurs when `wr_valid && wr_ready`.
- `wr_ready = !full && state != DONE`. This is combinational from registered state and count.
- States: LOAD → STREAM → DONE → LOAD.
  - **LOAD:** writes accepted; no pops; `char_valid=0`, `char_out=IDLE_CHAR`. `start` moves to STREAM. `start` is allowed while the FIFO is empty.
  - **STREAM:** pop every cycle the FIFO is non-empty. The popped byte appears on `char_out` next cycle with `char_valid=1` and `char_index` incremented.
    - If the FIFO is empty: no pop. `char_out=IDLE_CHAR` and `char_valid=0` next cycle (stall). The loader may keep writing during STREAM.
    - On a pop with last=1, go to DONE.
  - **DONE:** `char_out=IDLE_CHAR`, `char_valid=0`, writes refused. `clear` returns to LOAD and resets `char_index` to 0. Any residual FIFO entries written after the last byte are flushed on `clear`.
- `start` outside LOAD and `clear` outside DONE are ignored.
- If `start` and `clear` arrive in the same cycle, the current state decides which one acts; the other is ignored.
- A simultaneous push and pop in the same cycle leaves the count unchanged. Pushing while full is impossible because `wr_ready=0`.
- A `wr_valid` with `wr_ready=0` is not consumed; the loader holds its data.
- `char_index` is 32-bit and wraps modulo 2^32. Wrap is not flagged.
- A byte with last=1 that is not the final write is legal. Streaming ends at it.

## Timing
- Reset values: `char_out=IDLE_CHAR`, `char_valid=0`, `char_index=0`, `busy=0`, `done=0`, FIFO empty, state LOAD. `wr_ready=1` in the cycle after reset.
- Latency from a pop to `char_out` is 1 cycle. From `start` with the FIFO non-empty, the first `char_valid` appears 2 cycles after the `start` edge (state change, then pop).
- `done` rises in the same cycle that the last byte is on `char_out` plus 1. The solver's result is final one cycle after `done` first rises, because the solver registers its output.
- Throughput is 1 byte per clock in STREAM while the FIFO is non-empty.
- Reset asserted mid-stream: all outputs return to reset values on the next edge; FIFO contents are discarded.

## Structure
- `feeder_pkg` holds:
  - `feeder_state_t` enum {LOAD, STREAM, DONE};
  - the `IDLE_CHAR` default;
  - the 9-bit entry typedef `feeder_entry_t`.
- Sub-module `sync_fifo`: parameterised width and depth, synchronous reset, push/pop/full/empty/count, with a flush input driven by `clear`.
- FSM, output registers and index counter live in `puzzle_feeder`.

## Test plan
- Load "(()" with `wr_last` on ")", then `start`. Expect `char_out` '(' '(' ')' on consecutive cycles with index 1,2,3, then `done`. The chained solver result is 1.
- `DEPTH=4`: write 5 bytes back-to-back. Expect `wr_ready` low after the 4th push. The 5th byte is accepted the cycle after the first pop in STREAM.
- `start` on an empty FIFO, then write ")" with last 3 cycles later. Expect `char_valid=0` and `char_out=8'h00` during the stall, then ')' at index 1, then `done`. Solver result is -1.
- Write concurrently during STREAM so that push and pop coincide. The count stays constant and no byte is lost or reordered. Check 16 bytes against a reference sequence.
- Assert `rst` on the 2nd streamed byte. Next cycle all outputs are at reset values, state is LOAD, and `wr_ready=1`.
- From DONE: writes are refused (`wr_ready=0`). `clear` gives LOAD with `char_index=0`; a reload then streams correctly from index 1.

Source files
------------

// File: rtl/feeder_pkg.sv
// Shared types and defaults for the puzzle feeder: controller state,
// the idle character and the {last, data} FIFO entry layout.
package feeder_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

  // Byte that day solvers ignore; driven whenever no real character is valid.
  localparam logic [7:0] IDLE_CHAR_DEFAULT = 8'h00;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } feeder_entry_t;

  localparam int unsigned ENTRY_W = $bits(feeder_entry_t);

endpackage

// File: rtl/puzzle_feeder_if.sv
// Loader write port plus the character stream towards the day solver.
// master = loader/solver side, slave = the feeder itself.
interface puzzle_feeder_if;

  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic        start;
  logic        clear;
  logic [7:0]  char_out;
  logic        char_valid;
  logic [31:0] char_index;
  logic        busy;
  logic        done;

  modport master (
    output wr_valid, wr_data, wr_last, start, clear,
    input  wr_ready, char_out, char_valid, char_index, busy, done
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, start, clear,
    output wr_ready, char_out, char_valid, char_index, busy, done
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a synchronous flush.
// Read data is the current head entry (show-ahead), valid while !empty_o.
module sync_fifo #(
  parameter  int unsigned WIDTH = 9,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if a caller misbehaves.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; flush empties the FIFO like reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; empty/full come from the
    // reset pointers, so stale contents are never observed and the array
    // can map onto plain RAM.
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/puzzle_feeder.sv
// Buffers puzzle-input bytes from a valid/ready loader and streams them one
// per clock to a day solver, then parks in DONE so the solver's result can be
// sampled at a known cycle.
module puzzle_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [7:0]  IDLE_CHAR = IDLE_CHAR_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  puzzle_feeder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  feeder_state_t     state_q, state_d;
  logic [7:0]        char_out_q, char_out_d;
  logic              char_valid_q, char_valid_d;
  logic              char_last_q, char_last_d;
  logic [31:0]       char_index_q, char_index_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENTRY_W-1:0] fifo_rdata;
  feeder_entry_t     wr_entry, head;
  logic              wr_ready;

  assign wr_entry = '{last: bus.wr_last, data: bus.wr_data};
  assign head     = feeder_entry_t'(fifo_rdata);

  // Writes are refused in DONE so residual bytes cannot pile up after the end.
  assign wr_ready  = !fifo_full && (state_q != DONE);
  assign fifo_push = bus.wr_valid && wr_ready;
  // Once the last byte is on char_out nothing more is popped; anything left
  // behind it is residual and gets flushed by clear.
  assign fifo_pop   = (state_q == STREAM) && !fifo_empty && !char_last_q;
  assign fifo_flush = (state_q == DONE) && bus.clear;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (wr_entry),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Occupancy can never exceed the configured depth.
  a_count_in_range : assert property (
    @(posedge clk) disable iff (rst) fifo_count <= CNT_W'(DEPTH)
  );

  // Next-state logic: DONE is entered the cycle after the last byte was
  // presented, so done always trails the final character by one clock.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      LOAD:    if (bus.start)  state_d = STREAM;
      STREAM:  if (char_last_q) state_d = DONE;
      DONE:    if (bus.clear)  state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Output register next values: a pop presents its byte next cycle, an idle
  // cycle presents IDLE_CHAR, the index advances only on real characters.
  always_comb begin
    char_out_d   = IDLE_CHAR;
    char_valid_d = 1'b0;
    char_last_d  = 1'b0;
    char_index_d = char_index_q;
    if (fifo_pop) begin
      char_out_d   = head.data;
      char_valid_d = 1'b1;
      char_last_d  = head.last;
      char_index_d = char_index_q + 32'd1;
    end
    if (fifo_flush) char_index_d = '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      char_out_q   <= IDLE_CHAR;
      char_valid_q <= 1'b0;
      char_last_q  <= 1'b0;
      char_index_q <= '0;
    end else begin
      state_q      <= state_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      char_last_q  <= char_last_d;
      char_index_q <= char_index_d;
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.char_out   = char_out_q;
  assign bus.char_valid = char_valid_q;
  assign bus.char_index = char_index_q;
  assign bus.busy       = (state_q == STREAM);
  assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_puzzle_feeder.sv
// Bench for puzzle_feeder: a DEPTH=64 instance under a queue-based reference
// monitor plus directed scenarios, and a DEPTH=4 instance for full-FIFO timing.
module tb_puzzle_feeder;
  import feeder_pkg::*;

  localparam int unsigned DEPTH_BIG   = 64;
  localparam int unsigned DEPTH_SMALL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  puzzle_feeder_if bus_big ();
  puzzle_feeder_if bus_small ();

  puzzle_feeder #(.DEPTH(DEPTH_BIG), .IDLE_CHAR(8'h00)) u_dut_big (
    .clk (clk), .rst (rst), .bus (bus_big)
  );
  puzzle_feeder #(.DEPTH(DEPTH_SMALL), .IDLE_CHAR(8'h00)) u_dut_small (
    .clk (clk), .rst (rst), .bus (bus_small)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model for the big instance ----------------
  typedef enum {PH_LOAD, PH_STREAM, PH_DONE} phase_t;
  feeder_entry_t pend_q[$];   // accepted bytes still owed to the solver side
  logic [31:0]   exp_idx;
  phase_t        phase;
  bit            mon_en = 1'b0;
  int            floor_lvl;   // day-1 style solver run on observed characters
  int            got_cnt;

  always @(negedge clk) begin : monitor
    feeder_entry_t e;
    bit            saw_last;
    logic          exp_ready;
    if (mon_en) begin
      saw_last = 1'b0;
      if (bus_big.char_valid) begin
        check("valid_phase", phase == PH_STREAM, 1'b1);
        if (pend_q.size() == 0) begin
          check("spurious_char", 1'b1, 1'b0);
        end else begin
          e       = pend_q.pop_front();
          exp_idx = exp_idx + 32'd1;
          check("char_out", bus_big.char_out, e.data);
          check("char_index", bus_big.char_index, exp_idx);
          saw_last = e.last;
          got_cnt++;
          if (e.data == "(") floor_lvl++;
          else if (e.data == ")") floor_lvl--;
        end
      end else begin
        check("idle_char", bus_big.char_out, 8'h00);
        check("index_hold", bus_big.char_index, exp_idx);
      end
      exp_ready = (phase != PH_DONE) && (pend_q.size() < DEPTH_BIG);
      check("busy", bus_big.busy, phase == PH_STREAM);
      check("done", bus_big.done, phase == PH_DONE);
      check("wr_ready", bus_big.wr_ready, exp_ready);

      if (rst) begin
        pend_q.delete();
        exp_idx = '0;
        phase   = PH_LOAD;
      end else begin
        if (bus_big.wr_valid && exp_ready)
          pend_q.push_back('{last: bus_big.wr_last, data: bus_big.wr_data});
        case (phase)
          PH_LOAD:   if (bus_big.start) phase = PH_STREAM;
          PH_STREAM: if (saw_last) phase = PH_DONE;
          PH_DONE:   if (bus_big.clear) begin
                       pend_q.delete();
                       exp_idx = '0;
                       phase   = PH_LOAD;
                     end
          default:   phase = PH_LOAD;
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_big(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    bus_big.wr_valid = 1'b1;
    bus_big.wr_data  = d;
    bus_big.wr_last  = l;
    while (!bus_big.wr_ready && n < 64) begin
      cyc();
      n++;
    end
    check("write_accept", bus_big.wr_ready, 1'b1);
    cyc();
    bus_big.wr_valid = 1'b0;
    bus_big.wr_last  = 1'b0;
  endtask

  task automatic pulse_start_big();
    bus_big.start = 1'b1;
    cyc();
    bus_big.start = 1'b0;
  endtask

  task automatic pulse_clear_big();
    bus_big.clear = 1'b1;
    cyc();
    bus_big.clear = 1'b0;
  endtask

  task automatic wait_done_big(input int budget);
    int n;
    n = 0;
    while (!bus_big.done && n < budget) begin
      cyc();
      n++;
    end
    check("done_reached", bus_big.done, 1'b1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] sdata [5];
    int         base;
    bit         reached;

    rst = 1'b1;
    bus_big.wr_valid = 1'b0; bus_big.wr_data = '0; bus_big.wr_last = 1'b0;
    bus_big.start = 1'b0;    bus_big.clear = 1'b0;
    bus_small.wr_valid = 1'b0; bus_small.wr_data = '0; bus_small.wr_last = 1'b0;
    bus_small.start = 1'b0;    bus_small.clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    pend_q.delete();
    exp_idx   = '0;
    phase     = PH_LOAD;
    floor_lvl = 0;
    got_cnt   = 0;
    mon_en    = 1'b1;

    // Reset state on both instances.
    check("rst_char_valid", bus_big.char_valid, 1'b0);
    check("rst_char_out", bus_big.char_out, 8'h00);
    check("rst_char_index", bus_big.char_index, 32'd0);
    check("rst_busy", bus_big.busy, 1'b0);
    check("rst_done", bus_big.done, 1'b0);
    check("rst_wr_ready", bus_big.wr_ready, 1'b1);
    check("rst_small_ready", bus_small.wr_ready, 1'b1);

    // "(()" with last on the final ')'.
    floor_lvl = 0;
    write_big("(", 1'b0);
    write_big("(", 1'b0);
    write_big(")", 1'b1);
    pulse_start_big();
    check("t1_busy", bus_big.busy, 1'b1);
    check("t1_no_char_yet", bus_big.char_valid, 1'b0);
    cyc();
    check("t1_c1_valid", bus_big.char_valid, 1'b1);
    check("t1_c1", bus_big.char_out, "(");
    check("t1_i1", bus_big.char_index, 32'd1);
    cyc();
    check("t1_c2", bus_big.char_out, "(");
    check("t1_i2", bus_big.char_index, 32'd2);
    cyc();
    check("t1_c3", bus_big.char_out, ")");
    check("t1_i3", bus_big.char_index, 32'd3);
    check("t1_not_done_yet", bus_big.done, 1'b0);
    cyc();
    check("t1_done", bus_big.done, 1'b1);
    check("t1_idle", bus_big.char_valid, 1'b0);
    check("t1_floor", floor_lvl, 1);
    pulse_clear_big();
    check("t1_clear_index", bus_big.char_index, 32'd0);
    check("t1_clear_ready", bus_big.wr_ready, 1'b1);

    // Start on an empty FIFO, byte arrives later.
    floor_lvl = 0;
    pulse_start_big();
    repeat (2) begin
      check("t2_stall_valid", bus_big.char_valid, 1'b0);
      check("t2_stall_out", bus_big.char_out, 8'h00);
      cyc();
    end
    write_big(")", 1'b1);
    cyc();
    check("t2_char", bus_big.char_out, ")");
    check("t2_index", bus_big.char_index, 32'd1);
    cyc();
    check("t2_done", bus_big.done, 1'b1);
    check("t2_floor", floor_lvl, -1);
    pulse_clear_big();

    // Concurrent push/pop: preload 4, then hold wr_valid for 12 more.
    base = got_cnt;
    for (int i = 0; i < 4; i++) write_big(8'($urandom_range(0, 255)), 1'b0);
    pulse_start_big();
    for (int i = 0; i < 12; i++) begin
      bus_big.wr_valid = 1'b1;
      bus_big.wr_data  = 8'($urandom_range(0, 255));
      bus_big.wr_last  = (i == 11);
      bus_big.clear    = (i == 5);   // ignored outside DONE
      check("t3_b2b_ready", bus_big.wr_ready, 1'b1);
      cyc();
    end
    bus_big.wr_valid = 1'b0;
    bus_big.wr_last  = 1'b0;
    bus_big.clear    = 1'b0;
    wait_done_big(40);
    check("t3_count", got_cnt - base, 16);
    // start and clear together in DONE: clear acts, start is ignored.
    bus_big.start = 1'b1;
    bus_big.clear = 1'b1;
    cyc();
    bus_big.start = 1'b0;
    bus_big.clear = 1'b0;
    cyc();
    check("t3_start_ignored", bus_big.busy, 1'b0);

    // Random gaps between writes, start mid-load.
    base = got_cnt;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      write_big(8'($urandom_range(0, 255)), i == 19);
      if (i == 2) pulse_start_big();
    end
    wait_done_big(40);
    check("t4_count", got_cnt - base, 20);
    pulse_clear_big();

    // Reset on the 2nd streamed byte.
    for (int i = 0; i < 5; i++) write_big(8'($urandom_range(0, 255)), i == 4);
    pulse_start_big();
    reached = 1'b0;
    for (int n = 0; n < 10 && !reached; n++) begin
      cyc();
      if (bus_big.char_valid && bus_big.char_index == 32'd2) reached = 1'b1;
    end
    check("t5_second_byte", reached, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t5_valid", bus_big.char_valid, 1'b0);
    check("t5_out", bus_big.char_out, 8'h00);
    check("t5_index", bus_big.char_index, 32'd0);
    check("t5_busy", bus_big.busy, 1'b0);
    check("t5_done", bus_big.done, 1'b0);
    check("t5_ready", bus_big.wr_ready, 1'b1);
    pulse_start_big();
    repeat (3) begin
      check("t5_fifo_discarded", bus_big.char_valid, 1'b0);
      cyc();
    end
    write_big("A", 1'b1);
    wait_done_big(10);
    pulse_clear_big();

    // DONE refuses writes, clear flushes residue, reload restarts at index 1.
    write_big("(", 1'b0);
    write_big(")", 1'b1);
    write_big("(", 1'b0);
    write_big("(", 1'b0);
    pulse_start_big();
    wait_done_big(20);
    bus_big.wr_valid = 1'b1;
    bus_big.wr_data  = "x";
    repeat (3) begin
      check("t6_refuse", bus_big.wr_ready, 1'b0);
      cyc();
    end
    bus_big.wr_valid = 1'b0;
    pulse_clear_big();
    check("t6_index", bus_big.char_index, 32'd0);
    check("t6_load", bus_big.done, 1'b0);
    check("t6_ready", bus_big.wr_ready, 1'b1);
    floor_lvl = 0;
    write_big("(", 1'b0);
    write_big("(", 1'b1);
    pulse_start_big();
    cyc();
    check("t6_reload_char", bus_big.char_out, "(");
    check("t6_reload_index", bus_big.char_index, 32'd1);
    wait_done_big(10);
    check("t6_floor", floor_lvl, 2);
    pulse_clear_big();

    // DEPTH=4: five back-to-back writes, 5th waits for the first pop.
    for (int i = 0; i < 5; i++) sdata[i] = 8'($urandom_range(0, 255));
    bus_small.wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_small.wr_data = sdata[i];
      bus_small.wr_last = 1'b0;
      check("s_ready_pre", bus_small.wr_ready, 1'b1);
      cyc();
    end
    bus_small.wr_data = sdata[4];
    bus_small.wr_last = 1'b1;
    check("s_full", bus_small.wr_ready, 1'b0);
    bus_small.start = 1'b1;
    cyc();
    bus_small.start = 1'b0;
    check("s_full_stream", bus_small.wr_ready, 1'b0);
    check("s_busy", bus_small.busy, 1'b1);
    cyc();
    check("s_c0", bus_small.char_out, sdata[0]);
    check("s_i0", bus_small.char_index, 32'd1);
    check("s_ready_after_pop", bus_small.wr_ready, 1'b1);
    cyc();
    bus_small.wr_valid = 1'b0;
    bus_small.wr_last  = 1'b0;
    check("s_c1", bus_small.char_out, sdata[1]);
    check("s_i1", bus_small.char_index, 32'd2);
    for (int k = 2; k < 5; k++) begin
      cyc();
      check("s_ck_valid", bus_small.char_valid, 1'b1);
      check("s_ck", bus_small.char_out, sdata[k]);
      check("s_ik", bus_small.char_index, 32'(k + 1));
    end
    cyc();
    check("s_done", bus_small.done, 1'b1);
    check("s_idle", bus_small.char_valid, 1'b0);
    bus_small.clear = 1'b1;
    cyc();
    bus_small.clear = 1'b0;
    check("s_clear_index", bus_small.char_index, 32'd0);

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
